mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
- Sequencing controller for one time-shared `mac` instance (unsigned activation × signed weight + 16-bit psum).
- Accepts a job (length, initial psum) and streams activation/weight pairs through the MAC under valid/ready handshake.
- Holds the running partial sum in its own accumulator register and delivers the final psum on a valid/ready output port.
- Sits between the operand fetch logic (L0/IFIFO side) and the psum writeback/OFIFO in the PE array.

Parameters:
- bw, 4, activation/weight width
- psum_bw, 16, partial-sum / accumulator width
- len_bw, 8, width of job length field

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  job request; sampled only in IDLE
- len  input  len_bw  number of operand pairs in the job (0 allowed)
- psum_init  input  psum_bw  initial accumulator value, captured with start
- busy  output  1  high in any state other than IDLE
- in_valid  input  1  operand pair valid
- in_ready  output  1  controller accepts the operand pair
- in_a  input  bw  activation (unsigned)
- in_b  input  bw  weight (two's complement)
- mac_a  output  bw  to mac.a; equals in_a
- mac_b  output  bw  to mac.b; equals in_b
- mac_c  output  psum_bw  to mac.c; equals accumulator
- mac_out  input  psum_bw  from mac.out (combinational)
- out_valid  output  1  final psum valid
- out_ready  input  1  downstream accepts psum
- out_psum  output  psum_bw  final psum; equals accumulator

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: acc=0, count=0, len_q=0, busy=0, in_ready=0, out_valid=0, out_psum=0. mac_c follows acc, so it is 0 in reset.
- IDLE:
  - On start=1: acc<=psum_init, len_q<=len, count<=0.
  - Next state is RUN if len!=0, else DONE.
- RUN:
  - in_ready=1 combinationally.
  - A handshake (in_valid && in_ready) sets acc<=mac_out and count<=count+1.
  - If the handshake occurs with count==len_q-1, next state is DONE.
  - in_valid=0 stalls: acc and count hold. Gaps of any length are allowed.
- DONE:
  - out_valid=1, out_psum=acc, in_ready=0.
  - When out_ready=1 on a clock edge, next state is IDLE.
  - out_ready=0 holds DONE with out_psum stable.
- in_ready=0 and out_valid=0 in every state except as stated above.
- Latency:
  - out_valid rises the cycle after the final input handshake.
  - For len=0, out_valid rises the cycle after start.
  - The earliest new start is the cycle after the output handshake (IDLE for one cycle minimum).
- start while busy=1 is ignored; no queuing.
- mac_a/mac_b are direct wires from in_a/in_b. The mac is purely combinational; its result is registered only on a handshake.
- Arithmetic:
  - acc is modulo 2^psum_bw. The mac adder's carry-out is discarded, so overflow wraps silently.
  - Product = zero-extended a × sign-extended b.
- Reset asserted mid-job returns the block to IDLE immediately with all state cleared. The partial job is lost and no out_valid is produced.
- len_q and psum_init are captured at start; changes on len/psum_init during a job have no effect.

Test Plan:
- Basic job: reset, then start with len=3, psum_init=0, then pairs (3,2), (5,4'hF), (15,4'h8) back-to-back -> out_valid 1 cycle after third handshake, out_psum=16'hFF89 (6−5−120=−119).
- Stalls/backpressure:
  - Same job with in_valid low for 2 cycles between pairs -> identical result, acc unchanged during gaps.
  - Hold out_ready=0 for 5 cycles -> out_valid/out_psum stable, then IDLE one cycle after out_ready=1.
- Zero length: start with len=0, psum_init=16'h1234 -> in_ready never asserted, out_valid next cycle with out_psum=16'h1234.
- Wrap-around: len=1, psum_init=16'h7FFF, pair (1,1) -> out_psum=16'h8000. Then len=1, psum_init=16'hFFFF, pair (1,1) -> out_psum=16'h0000.
- Reset mid-run: len=4, assert reset (0) after 2 handshakes -> busy, in_ready, out_valid drop immediately; after release a new len=1 job with psum_init=0 and pair (2,3) yields 16'h0006.
- Start while busy: pulse start with len=7 during RUN of a len=2 job -> ignored; job completes after exactly 2 handshakes with the original result.

Source files
------------

// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if: job, operand, mac and result signals of the MAC sequencing controller.
interface mac_seq_ctrl_if #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int len_bw  = 8
);
  logic               start;
  logic [len_bw-1:0]  len;
  logic [psum_bw-1:0] psum_init;
  logic               busy;
  logic               in_valid;
  logic               in_ready;
  logic [bw-1:0]      in_a;
  logic [bw-1:0]      in_b;
  logic [bw-1:0]      mac_a;
  logic [bw-1:0]      mac_b;
  logic [psum_bw-1:0] mac_c;
  logic [psum_bw-1:0] mac_out;
  logic               out_valid;
  logic               out_ready;
  logic [psum_bw-1:0] out_psum;
  modport slave (
    input  start, len, psum_init, in_valid, in_a, in_b, mac_out, out_ready,
    output busy, in_ready, mac_a, mac_b, mac_c, out_valid, out_psum
  );
  modport master (
    output start, len, psum_init, in_valid, in_a, in_b, mac_out, out_ready,
    input  busy, in_ready, mac_a, mac_b, mac_c, out_valid, out_psum
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: streams a job of operand pairs through one shared combinational mac
// and hands the accumulated psum downstream over a valid/ready port.
module mac_seq_ctrl #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int len_bw  = 8
) (
  input logic           clk,
  input logic           reset,
  mac_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q;
  logic [psum_bw-1:0] acc_q;
  logic [len_bw-1:0]  count_q;
  logic [len_bw-1:0]  len_q;
  logic               busy_q;
  logic               in_ready_q;
  logic               out_valid_q;
  assign bus.mac_a     = bw'(bus.in_a);
  assign bus.mac_b     = bw'(bus.in_b);
  assign bus.mac_c     = acc_q;
  assign bus.out_psum  = acc_q;
  assign bus.busy      = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  // Handshake flags are decoded from the next state so they stay registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      len_q       <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (bus.start) begin
        acc_q       <= bus.psum_init;
        len_q       <= bus.len;
        count_q     <= '0;
        busy_q      <= 1'b1;
        state_q     <= (bus.len != '0) ? RUN : DONE;
        in_ready_q  <= (bus.len != '0);
        out_valid_q <= (bus.len == '0);
      end
    end else if (state_q == RUN) begin
      if (bus.in_valid) begin
        acc_q   <= bus.mac_out;
        count_q <= count_q + len_bw'(1);
        if (count_q + len_bw'(1) == len_q) begin
          state_q     <= DONE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b1;
        end
      end
    end else if (bus.out_ready) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: randomized jobs against an arithmetic reference; a scoreboard
// queue of expected psums is drained by an independent output monitor.
module tb_mac_seq_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [15:0] sb[$];
  logic [3:0] qa[$], qb[$];
  mac_seq_ctrl_if #(.bw(4), .psum_bw(16), .len_bw(8)) bus();
  mac_seq_ctrl #(.bw(4), .psum_bw(16), .len_bw(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic int prod_f(input logic [3:0] a, input logic [3:0] b);
    return int'(a) * (int'(b) - (b[3] ? 16 : 0));
  endfunction
  // Behavioural stand-in for the combinational mac the controller drives.
  assign bus.mac_out = bus.mac_c + 16'(prod_f(bus.mac_a, bus.mac_b));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: got psum %h with no job pending", bus.out_psum);
      end else chk("sb_psum", 32'(bus.out_psum), 32'(sb.pop_front()));
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic rand_pairs(input int n);
    qa = {};
    qb = {};
    for (int i = 0; i < n; i++) begin
      qa.push_back(4'($urandom));
      qb.push_back(4'($urandom));
    end
  endtask
  task automatic job(input logic [15:0] pinit, input int gmin, input int gmax, input int hold, input bit glitch);
    logic [15:0] exp, acc;
    int n;
    n = qa.size();
    exp = pinit;
    for (int i = 0; i < n; i++) exp = exp + 16'(prod_f(qa[i], qb[i]));
    sb.push_back(exp);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len = 8'(n);
    bus.psum_init = pinit;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.len = 8'($urandom);
    bus.psum_init = 16'($urandom);
    acc = pinit;
    if (glitch) begin
      bus.start = 1'b1;
      bus.len = 8'd7;
      @(negedge clk);
      chk("busy_run", 32'(bus.busy), 1);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      for (int g = $urandom_range(gmax, gmin); g > 0; g--) begin
        bus.in_valid = 1'b0;
        bus.in_a = 4'($urandom);
        bus.in_b = 4'($urandom);
        @(negedge clk);
        chk("gap_acc_hold", 32'(bus.mac_c), 32'(acc));
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_a = qa[i];
      bus.in_b = qb[i];
      @(negedge clk);
      chk("in_ready_run", 32'(bus.in_ready), 1);
      chk("mac_c_acc", 32'(bus.mac_c), 32'(acc));
      chk("mac_ab_wires", 32'({bus.mac_a, bus.mac_b}), 32'({qa[i], qb[i]}));
      acc = acc + 16'(prod_f(qa[i], qb[i]));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      chk("out_valid_done", 32'(bus.out_valid), 1);
      chk("out_psum_stable", 32'(bus.out_psum), 32'(exp));
      chk("in_ready_done", 32'(bus.in_ready), 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_out_valid", 32'(bus.out_valid), 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.len = '0;
    bus.psum_init = '0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_psum", 32'(bus.out_psum), 0);
    chk("rst_mac_c", 32'(bus.mac_c), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    qa = '{4'd3, 4'd5, 4'd15};
    qb = '{4'd2, 4'hF, 4'h8};
    job(16'h0000, 0, 0, 0, 1'b0);
    job(16'h0000, 2, 2, 0, 1'b0);
    job(16'h0000, 0, 0, 5, 1'b0);
    qa = {};
    qb = {};
    job(16'h1234, 0, 0, 0, 1'b0);
    qa = '{4'd1};
    qb = '{4'd1};
    job(16'h7FFF, 0, 0, 0, 1'b0);
    job(16'hFFFF, 0, 0, 0, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len = 8'd4;
    bus.psum_init = 16'($urandom);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a = 4'($urandom);
      bus.in_b = 4'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_in_ready", 32'(bus.in_ready), 0);
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_mac_c", 32'(bus.mac_c), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("postrst_busy", 32'(bus.busy), 0);
    qa = '{4'd2};
    qb = '{4'd3};
    job(16'h0000, 0, 0, 0, 1'b0);
    rand_pairs(2);
    job(16'($urandom), 0, 1, 0, 1'b1);
    for (int j = 0; j < 30; j++) begin
      rand_pairs($urandom_range(6, 0));
      job(16'($urandom), 0, 2, $urandom_range(3, 0), 1'b0);
    end
    rand_pairs(20);
    job(16'($urandom), 0, 1, 1, 1'b0);
    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
